cp0_timer: RTL and testbench



---
 rtl/cp0_timer.sv | 188 ++++++++++++++++++
 tb/tb_cp0_timer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer.sv
// cp0_timer: coprocessor-0 for the pipelined MIPS core.
// Handles SR/Cause/EPC exception entry and eret, a configurable number of
// external interrupt lines, a Count/Compare timer with a sticky pending bit,
// BadVAddr capture on address errors, and a read-only PrID.
//
// Handshake: there is no valid/ready pair here. Req is a combinational
// request to the PC-select logic; the entry it announces is committed on the
// next rising clk edge. An mtc0 write (en) is accepted on the same edge only
// when Req is 0; when Req is 1 the write is dropped.
module cp0_timer #(
  parameter int          NUM_HWINT = 6,
  parameter int          TIMER_IDX = 5,
  parameter logic [31:0] PRID_VAL  = 32'h2137_3293
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 BDIn,
  input  logic                 EXLClr,
  input  logic [4:0]           ExcCodeIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic [4:0]           CP0Addr,
  input  logic [31:0]          CP0In,
  input  logic [31:0]          vPC,
  input  logic [31:0]          BadVAddrIn,
  output logic                 Req,
  output logic [31:0]          EPCout,
  output logic [31:0]          CP0out,
  output logic                 TimerIrq
);

  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_SR       = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  // Architectural state
  logic        sr_ie_q,     sr_ie_d;
  logic        sr_exl_q,    sr_exl_d;
  logic [5:0]  sr_im_q,     sr_im_d;
  logic        cause_bd_q,  cause_bd_d;
  logic        ti_q,        ti_d;
  logic [5:0]  ip_q,        ip_d;
  logic [4:0]  exccode_q,   exccode_d;
  logic [31:0] epc_q,       epc_d;
  logic [31:0] badvaddr_q,  badvaddr_d;
  logic [31:0] count_q,     count_d;
  logic [31:0] compare_q,   compare_d;

  // Combinational helpers
  logic [5:0]  ipvec;
  logic        int_req;
  logic        exc_req;
  logic        wr_en;
  logic        wr_sr;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic        addr_err;

  // Build the pending-interrupt vector: external lines plus the timer bit.
  always_comb begin
    ipvec = '0;
    for (int i = 0; i < NUM_HWINT; i++) begin
      ipvec[i] = HWInt[i];
    end
    ipvec[TIMER_IDX] = ipvec[TIMER_IDX] | ti_q;
  end

  // Request generation and the EPC handed to PC-select; interrupts win.
  always_comb begin
    int_req  = (|(sr_im_q & ipvec)) & sr_ie_q & ~sr_exl_q;
    exc_req  = (ExcCodeIn != 5'd0) & ~sr_exl_q;
    Req      = int_req | exc_req;
    EPCout   = Req ? (BDIn ? (vPC - 32'd4) : vPC) : epc_q;
    TimerIrq = ti_q;
  end

  // mtc0 decode; writes are suppressed while an entry is being requested.
  always_comb begin
    wr_en      = en & ~Req;
    wr_sr      = wr_en & (CP0Addr == ADDR_SR);
    wr_epc     = wr_en & (CP0Addr == ADDR_EPC);
    wr_count   = wr_en & (CP0Addr == ADDR_COUNT);
    wr_compare = wr_en & (CP0Addr == ADDR_COMPARE);
    addr_err   = (ExcCodeIn == 5'd4) | (ExcCodeIn == 5'd5);
  end

  // SR next state: mtc0 first, then eret clears EXL, then entry sets it.
  always_comb begin
    sr_ie_d  = sr_ie_q;
    sr_exl_d = sr_exl_q;
    sr_im_d  = sr_im_q;
    if (wr_sr) begin
      sr_ie_d  = CP0In[0];
      sr_exl_d = CP0In[1];
      sr_im_d  = CP0In[15:10];
    end
    if (EXLClr) begin
      sr_exl_d = 1'b0;
    end
    if (Req) begin
      sr_exl_d = 1'b1;
    end
  end

  // Cause, EPC and BadVAddr next state on exception/interrupt entry.
  always_comb begin
    cause_bd_d = cause_bd_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    ip_d       = ipvec;
    if (wr_epc) begin
      epc_d = CP0In;
    end
    if (Req) begin
      cause_bd_d = BDIn;
      epc_d      = EPCout;
      exccode_d  = int_req ? 5'd0 : ExcCodeIn;
      if (exc_req && !int_req && addr_err) begin
        badvaddr_d = BadVAddrIn;
      end
    end
  end

  // Timer: free-running Count, Compare register and sticky TI bit.
  always_comb begin
    count_d   = wr_count ? CP0In : (count_q + 32'd1);
    compare_d = wr_compare ? CP0In : compare_q;
    ti_d      = ti_q;
    if (count_q == compare_q) begin
      ti_d = 1'b1;
    end
    if (wr_compare) begin
      ti_d = 1'b0;
    end
  end

  // mfc0 read mux; unimplemented registers and bits read as zero.
  always_comb begin
    CP0out = 32'd0;
    case (CP0Addr)
      ADDR_BADVADDR: CP0out = badvaddr_q;
      ADDR_COUNT:    CP0out = count_q;
      ADDR_COMPARE:  CP0out = compare_q;
      ADDR_SR:       CP0out = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      ADDR_CAUSE:    CP0out = {cause_bd_q, ti_q, 2'b00, 1'b0, 11'd0,
                               ip_q, 3'd0, exccode_q, 2'b00};
      ADDR_EPC:      CP0out = epc_q;
      ADDR_PRID:     CP0out = PRID_VAL;
      default:       CP0out = 32'd0;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr_ie_q    <= 1'b0;
      sr_exl_q   <= 1'b0;
      sr_im_q    <= 6'd0;
      cause_bd_q <= 1'b0;
      ti_q       <= 1'b0;
      ip_q       <= 6'd0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'hFFFF_FFFF;
    end else begin
      sr_ie_q    <= sr_ie_d;
      sr_exl_q   <= sr_exl_d;
      sr_im_q    <= sr_im_d;
      cause_bd_q <= cause_bd_d;
      ti_q       <= ti_d;
      ip_q       <= ip_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
    end
  end

endmodule

// File: tb/tb_cp0_timer.sv
// Bench for cp0_timer: directed scenarios plus a randomized run checked
// against a word-level register model of coprocessor 0.
module tb_cp0_timer;

  localparam int          TIMER_IDX = 5;
  localparam logic [31:0] PRID      = 32'h2137_3293;

  // Clock / reset
  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic        reset_n, en, BDIn, EXLClr;
  logic [4:0]  ExcCodeIn, CP0Addr;
  logic [5:0]  HWInt;
  logic [1:0]  HWInt2;
  logic [31:0] CP0In, vPC, BadVAddrIn;
  logic        Req, TimerIrq, Req2, TimerIrq2;
  logic [31:0] EPCout, CP0out, EPCout2, CP0out2;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  cp0_timer dut (
    .clk(clk), .reset_n(reset_n), .en(en), .BDIn(BDIn), .EXLClr(EXLClr),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .CP0Addr(CP0Addr), .CP0In(CP0In),
    .vPC(vPC), .BadVAddrIn(BadVAddrIn), .Req(Req), .EPCout(EPCout),
    .CP0out(CP0out), .TimerIrq(TimerIrq)
  );

  cp0_timer #(.NUM_HWINT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .BDIn(BDIn), .EXLClr(EXLClr),
    .ExcCodeIn(ExcCodeIn), .HWInt(HWInt2), .CP0Addr(CP0Addr), .CP0In(CP0In),
    .vPC(vPC), .BadVAddrIn(BadVAddrIn), .Req(Req2), .EPCout(EPCout2),
    .CP0out(CP0out2), .TimerIrq(TimerIrq2)
  );

  // Reference model: whole 32-bit architectural register words
  logic [31:0] m_sr, m_cause, m_epc, m_bad, m_count, m_cmp;
  logic [31:0] n_sr, n_cause, n_epc, n_bad, n_count, n_cmp;

  function automatic logic [5:0] m_ipvec();
    logic [5:0] v;
    v = HWInt;
    v[TIMER_IDX] = v[TIMER_IDX] | m_cause[30];
    return v;
  endfunction

  function automatic logic m_int_req();
    return ((m_sr[15:10] & m_ipvec()) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_req() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_epcout();
    if (!m_req()) return m_epc;
    return BDIn ? (vPC - 32'd4) : vPC;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_cmp;
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_compute();
    logic req, intr, wr, ti, bd;
    logic [4:0] exc;
    if (!reset_n) begin
      n_sr = 0; n_cause = 0; n_epc = 0; n_bad = 0; n_count = 0;
      n_cmp = 32'hFFFF_FFFF;
      return;
    end
    req  = m_req();
    intr = m_int_req();
    wr   = en && !req;
    n_sr = m_sr;
    if (wr && CP0Addr == 5'd12) n_sr = CP0In & 32'h0000_FC03;
    if (EXLClr) n_sr[1] = 1'b0;
    if (req) n_sr[1] = 1'b1;
    n_epc = (wr && CP0Addr == 5'd14) ? CP0In : m_epc;
    if (req) n_epc = m_epcout();
    n_bad = m_bad;
    if (req && !intr && (ExcCodeIn == 5'd4 || ExcCodeIn == 5'd5)) n_bad = BadVAddrIn;
    n_count = (wr && CP0Addr == 5'd9) ? CP0In : m_count + 32'd1;
    n_cmp = (wr && CP0Addr == 5'd11) ? CP0In : m_cmp;
    ti = m_cause[30];
    if (m_count == m_cmp) ti = 1'b1;
    if (wr && CP0Addr == 5'd11) ti = 1'b0;
    bd  = req ? BDIn : m_cause[31];
    exc = req ? (intr ? 5'd0 : ExcCodeIn) : m_cause[6:2];
    n_cause = 32'd0;
    n_cause[31] = bd;
    n_cause[30] = ti;
    n_cause[15:10] = m_ipvec();
    n_cause[6:2] = exc;
  endtask

  // Driver: one clock cycle; inputs are changed only during clk low.
  task automatic tick();
    m_compute();
    @(posedge clk);
    m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    m_bad = n_bad; m_count = n_count; m_cmp = n_cmp;
    @(negedge clk);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    en = 1'b1; CP0Addr = a; CP0In = d;
    tick();
    en = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0]  addrs [7];
    logic [31:0] vals  [7];
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
    vals  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, PRID};
    reset_n = 1'b0;
    tick(); tick();
    #1;
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", Req); end
    checks++; if (EPCout !== 32'd0) begin errors++; $display("FAIL reset_epcout: got %h exp 0", EPCout); end
    checks++; if (TimerIrq !== 1'b0) begin errors++; $display("FAIL reset_ti: got %b exp 0", TimerIrq); end
    for (int i = 0; i < 7; i++) begin
      CP0Addr = addrs[i]; #1;
      checks++;
      if (CP0out !== vals[i]) begin
        errors++; $display("FAIL reset_reg%0d: got %h exp %h", addrs[i], CP0out, vals[i]);
      end
    end
    reset_n = 1'b1;
    tick();
    CP0Addr = 5'd9; #1;
    checks++; if (CP0out !== 32'd1) begin errors++; $display("FAIL reset_count_run: got %h exp 1", CP0out); end
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL reset_req_idle: got %b exp 0", Req); end
  endtask

  task automatic test_hw_interrupt();
    mtc0(5'd12, 32'h0000_FC01);
    HWInt = 6'b000100; vPC = 32'h0000_1000; BDIn = 1'b0; #1;
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL hwint_req: got %b exp 1", Req); end
    checks++; if (EPCout !== 32'h0000_1000) begin errors++; $display("FAIL hwint_epcout: got %h exp 1000", EPCout); end
    tick();
    HWInt = 6'd0; #1;
    checks++; if (Req !== 1'b0) begin errors++; $display("FAIL hwint_req_after: got %b exp 0", Req); end
    CP0Addr = 5'd13; #1;
    checks++; if (CP0out !== 32'h0000_1000) begin errors++; $display("FAIL hwint_cause: got %h exp 00001000", CP0out); end
    CP0Addr = 5'd12; #1;
    checks++; if (CP0out !== 32'h0000_FC03) begin errors++; $display("FAIL hwint_sr_exl: got %h exp 0000fc03", CP0out); end
    CP0Addr = 5'd14; #1;
    checks++; if (CP0out !== 32'h0000_1000) begin errors++; $display("FAIL hwint_epc: got %h exp 1000", CP0out); end
  endtask

  task automatic test_addr_exception();
    EXLClr = 1'b1; tick(); EXLClr = 1'b0;
    ExcCodeIn = 5'd4; BDIn = 1'b1; vPC = 32'h3008; BadVAddrIn = 32'h1235; #1;
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL adel_req: got %b exp 1", Req); end
    checks++; if (EPCout !== 32'h3004) begin errors++; $display("FAIL adel_epcout: got %h exp 3004", EPCout); end
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    CP0Addr = 5'd13; #1;
    checks++; if (CP0out !== 32'h8000_0010) begin errors++; $display("FAIL adel_cause: got %h exp 80000010", CP0out); end
    CP0Addr = 5'd8; #1;
    checks++; if (CP0out !== 32'h1235) begin errors++; $display("FAIL adel_badvaddr: got %h exp 1235", CP0out); end
    EXLClr = 1'b1; tick(); EXLClr = 1'b0;
    CP0Addr = 5'd12; #1;
    checks++; if (CP0out !== 32'h0000_FC01) begin errors++; $display("FAIL eret_sr: got %h exp 0000fc01", CP0out); end
  endtask

  task automatic test_timer();
    int n;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10);
    n = 0;
    while (TimerIrq !== 1'b1 && n < 40) begin tick(); n++; end
    checks++; if (TimerIrq !== 1'b1) begin errors++; $display("FAIL timer_set: got %b exp 1 within 40 cycles", TimerIrq); end
    CP0Addr = 5'd9; #1;
    checks++; if (CP0out !== 32'd11) begin errors++; $display("FAIL timer_set_count: got %0d exp 11", CP0out); end
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL timer_req: got %b exp 1", Req); end
    tick();
    CP0Addr = 5'd13; #1;
    checks++; if ((CP0out & 32'h4000_007C) !== 32'h4000_0000) begin errors++; $display("FAIL timer_cause: got %h exp TI=1 code=0", CP0out); end
    checks++; if (Req !== 1'b0 || TimerIrq !== 1'b1) begin errors++; $display("FAIL timer_sticky: got req=%b ti=%b exp 0 1", Req, TimerIrq); end
    mtc0(5'd11, 32'd50); #1;
    checks++; if (TimerIrq !== 1'b0) begin errors++; $display("FAIL timer_clear: got %b exp 0", TimerIrq); end
    EXLClr = 1'b1; tick(); EXLClr = 1'b0;
  endtask

  task automatic test_count_wrap();
    logic [31:0] e;
    mtc0(5'd11, 32'd0);
    mtc0(5'd9, 32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0001);
    CP0Addr = 5'd9;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      e = exp_q.pop_front();
      checks++; if (CP0out !== e) begin errors++; $display("FAIL wrap_count%0d: got %h exp %h", k, CP0out, e); end
      checks++; if (TimerIrq !== (k == 2)) begin errors++; $display("FAIL wrap_ti%0d: got %b exp %b", k, TimerIrq, (k == 2)); end
    end
    tick();
    mtc0(5'd11, 32'hFFFF_FFFF);
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_back_to_back();
    ExcCodeIn = 5'd8; vPC = 32'h4000; BDIn = 1'b0;
    en = 1'b1; CP0Addr = 5'd14; CP0In = 32'hDEAD_BEEF; EXLClr = 1'b1; #1;
    checks++; if (Req !== 1'b1) begin errors++; $display("FAIL b2b_req: got %b exp 1", Req); end
    tick();
    ExcCodeIn = 5'd0; en = 1'b0; EXLClr = 1'b0;
    CP0Addr = 5'd14; #1;
    checks++; if (CP0out !== 32'h4000) begin errors++; $display("FAIL b2b_epc: got %h exp 4000", CP0out); end
    CP0Addr = 5'd12; #1;
    checks++; if (CP0out !== 32'h2) begin errors++; $display("FAIL b2b_exl: got %h exp 2", CP0out); end
    CP0Addr = 5'd13; #1;
    checks++; if (CP0out[6:2] !== 5'd8) begin errors++; $display("FAIL b2b_exccode: got %0d exp 8", CP0out[6:2]); end
    en = 1'b1; CP0Addr = 5'd12; CP0In = 32'h0000_FC03; EXLClr = 1'b1;
    tick();
    en = 1'b0; EXLClr = 1'b0; #1;
    checks++; if (CP0out !== 32'h0000_FC01) begin errors++; $display("FAIL sr_then_eret: got %h exp 0000fc01", CP0out); end
    mtc0(5'd12, 32'd0);
  endtask

  task automatic test_hwint_width();
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    mtc0(5'd12, 32'h0000_FC00);
    HWInt = 6'd0; HWInt2 = 2'b11;
    tick();
    CP0Addr = 5'd13; #1;
    checks++; if (CP0out2[15:10] !== 6'b000011) begin errors++; $display("FAIL width_ip: got %b exp 000011", CP0out2[15:10]); end
    checks++; if (Req2 !== 1'b0) begin errors++; $display("FAIL width_req: got %b exp 0", Req2); end
    CP0Addr = 5'd0; #1;
    checks++; if (CP0out2 !== 32'd0 || CP0out !== 32'd0) begin errors++; $display("FAIL read_addr0: got %h/%h exp 0", CP0out, CP0out2); end
    CP0Addr = 5'd10; #1;
    checks++; if (CP0out2 !== 32'd0 || CP0out !== 32'd0) begin errors++; $display("FAIL read_addr10: got %h/%h exp 0", CP0out, CP0out2); end
    CP0Addr = 5'd15; #1;
    checks++; if (CP0out2 !== PRID || CP0out !== PRID) begin errors++; $display("FAIL read_prid: got %h/%h exp %h", CP0out, CP0out2, PRID); end
    HWInt2 = 2'b00;
  endtask

  task automatic test_random();
    logic [4:0] tbl [8];
    logic [31:0] er;
    tbl = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    for (int c = 0; c < 3000; c++) begin
      reset_n    = ($urandom_range(0, 299) != 0);
      en         = ($urandom_range(0, 2) == 0);
      CP0Addr    = tbl[$urandom_range(0, 7)];
      if (CP0Addr == 5'd0) CP0Addr = 5'($urandom_range(0, 31));
      CP0In      = $urandom;
      if (CP0Addr == 5'd11 && $urandom_range(0, 1) == 0) CP0In = m_count + 32'($urandom_range(0, 6));
      EXLClr     = ($urandom_range(0, 7) == 0);
      ExcCodeIn  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      HWInt      = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
      BDIn       = 1'($urandom_range(0, 1));
      vPC        = $urandom;
      BadVAddrIn = $urandom;
      #1;
      er = m_read(CP0Addr);
      checks++; if (Req !== m_req()) begin errors++; $display("FAIL rnd_req c%0d: got %b exp %b", c, Req, m_req()); end
      checks++; if (EPCout !== m_epcout()) begin errors++; $display("FAIL rnd_epcout c%0d: got %h exp %h", c, EPCout, m_epcout()); end
      checks++; if (TimerIrq !== m_cause[30]) begin errors++; $display("FAIL rnd_ti c%0d: got %b exp %b", c, TimerIrq, m_cause[30]); end
      checks++; if (CP0out !== er) begin errors++; $display("FAIL rnd_read c%0d a%0d: got %h exp %h", c, CP0Addr, CP0out, er); end
      tick();
    end
    reset_n = 1'b1; en = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0;
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; BDIn = 1'b0; EXLClr = 1'b0; ExcCodeIn = 5'd0;
    HWInt = 6'd0; HWInt2 = 2'd0; CP0Addr = 5'd0; CP0In = 32'd0;
    vPC = 32'd0; BadVAddrIn = 32'd0;
    @(negedge clk);
    test_reset();
    test_hw_interrupt();
    test_addr_exception();
    test_timer();
    test_count_wrap();
    test_back_to_back();
    test_hwint_width();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
